// File: rtl/traffic_generator_pkg.sv
// traffic_generator_pkg: packet layout, FSM states and LFSR taps shared by the NoC traffic sources
package traffic_generator_pkg;
  localparam int DEST_LSB = 16;
  localparam int PID_LSB = 6;
  localparam int PID_W = 10;
  localparam int ID_W = 6;
  localparam int COORD_W = 3;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {IDLE, WAIT_GAP, REQ, DONE} tg_state_e;
endpackage

// File: rtl/noc_lfsr16.sv
// noc_lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11) that steps only when advanced
module noc_lfsr16
  import traffic_generator_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed_i,
  input  logic        adv_i,
  output logic [15:0] state_o
);
  logic [15:0] state_q, state_d;
  always_comb state_d = adv_i ? {state_q[14:0], ^(state_q & LFSR_TAPS)} : state_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= seed_i;
    else state_q <= state_d;
  assign state_o = state_q;
endmodule

// File: rtl/traffic_generator.sv
// traffic_generator: single-flit packet source driving a router Local port with Req/Gnt handshake
module traffic_generator
  import traffic_generator_pkg::*;
#(
  parameter logic [5:0]  routerID     = 6'b000_000,
  parameter logic [5:0]  ModuleID     = 6'b000_000,
  parameter int          dataWidth    = 32,
  parameter int          dim          = 4,
  parameter int          DEST_MODE    = 0,
  parameter logic [5:0]  DEST_ID      = 6'b000_001,
  parameter int          INJ_INTERVAL = 4,
  parameter int          NUM_PACKETS  = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Enable,
  output logic [dataWidth-1:0] PacketOut,
  input  logic                 DnStrFull,
  output logic                 ReqDnStr,
  input  logic                 GntDnStr,
  output logic [15:0]          SentCount,
  output logic                 Done
);
  tg_state_e state_q, state_d;
  logic [dataWidth-1:0] pkt_q, pkt_d, pkt;
  logic [PID_W-1:0] pid_q, pid_d;
  logic [15:0] cnt_q, cnt_d, gap_q, gap_d, lfsr;
  logic [COORD_W-1:0] rx, ry, rx_adj;
  logic [2*COORD_W-1:0] dest;
  logic grant, last, unused_lfsr;
  noc_lfsr16 u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .seed_i (LFSR_SEED),
    .adv_i  (grant),
    .state_o(lfsr)
  );
  assign unused_lfsr = ^lfsr[15:2*COORD_W];
  assign rx = COORD_W'(32'(lfsr[COORD_W-1:0]) % dim);
  assign ry = COORD_W'(32'(lfsr[2*COORD_W-1:COORD_W]) % dim);
  // Random destinations never target our own router: nudge x by one instead
  assign rx_adj = {rx, ry} == routerID ? COORD_W'((32'(rx) + 1) % dim) : rx;
  assign dest = DEST_MODE == 1 ? {rx_adj, ry} : DEST_ID;
  assign grant = state_q == REQ && GntDnStr;
  assign last = NUM_PACKETS != 0 && 32'(cnt_q) + 1 == NUM_PACKETS;
  always_comb begin
    pkt = '0;
    pkt[DEST_LSB +: 2*COORD_W] = dest;
    pkt[PID_LSB +: PID_W] = pid_q;
    pkt[ID_W-1:0] = ModuleID;
    state_d = state_q;
    pkt_d = pkt_q;
    pid_d = pid_q;
    cnt_d = cnt_q;
    gap_d = gap_q;
    unique case (state_q)
      IDLE: if (Enable && !DnStrFull) begin
        state_d = REQ;
        pkt_d = pkt;
      end
      REQ: if (GntDnStr) begin
        pid_d = pid_q + PID_W'(1);
        cnt_d = cnt_q == 16'hFFFF ? cnt_q : cnt_q + 16'd1;
        gap_d = 16'(INJ_INTERVAL);
        state_d = last ? DONE : INJ_INTERVAL == 0 ? IDLE : WAIT_GAP;
      end
      WAIT_GAP: begin
        gap_d = gap_q - 16'd1;
        state_d = gap_q <= 16'd1 ? IDLE : WAIT_GAP;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      pkt_q <= '0;
      pid_q <= '0;
      cnt_q <= '0;
      gap_q <= '0;
    end else begin
      state_q <= state_d;
      pkt_q <= pkt_d;
      pid_q <= pid_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
    end
  assign PacketOut = pkt_q;
  assign ReqDnStr = state_q == REQ;
  assign SentCount = cnt_q;
  assign Done = state_q == DONE;
endmodule

// File: tb/tb_traffic_generator.sv
// tb_traffic_generator: directed scoreboard bench for fixed, unlimited and random-destination generators
module tb_traffic_generator;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, failures = 0;
  int sel = 0;
  logic [31:0] exp_q[$];

  logic en_f = 0, full_f = 0, man_f = 0, auto_f = 0, rsp_f;
  logic en_i = 0, full_i = 0, auto_i = 0, rsp_i;
  logic en_r = 0, full_r = 0, auto_r = 0, rsp_r;
  logic gnt_f, gnt_i, gnt_r, req_f, req_i, req_r, done_f, done_i, done_r, cur_req;
  logic [31:0] pkt_f, pkt_i, pkt_r;
  logic [15:0] cnt_f, cnt_i, cnt_r;

  assign gnt_f = auto_f ? rsp_f : man_f;
  assign gnt_i = auto_i & rsp_i;
  assign gnt_r = auto_r & rsp_r;
  always_comb cur_req = sel == 0 ? req_f : sel == 1 ? req_i : req_r;

  // collector-style responder: grant one cycle after seeing a request
  always @(posedge clk or negedge reset)
    if (!reset) begin
      rsp_f <= 0; rsp_i <= 0; rsp_r <= 0;
    end else begin
      rsp_f <= auto_f && req_f && !rsp_f;
      rsp_i <= auto_i && req_i && !rsp_i;
      rsp_r <= auto_r && req_r && !rsp_r;
    end

  traffic_generator #(.ModuleID(6'b000_011), .DEST_ID(6'b001_010), .INJ_INTERVAL(2), .NUM_PACKETS(3)) u_fix (
    .clk(clk), .reset(reset), .Enable(en_f), .PacketOut(pkt_f), .DnStrFull(full_f),
    .ReqDnStr(req_f), .GntDnStr(gnt_f), .SentCount(cnt_f), .Done(done_f));
  traffic_generator #(.ModuleID(6'd5), .INJ_INTERVAL(0), .NUM_PACKETS(0)) u_inf (
    .clk(clk), .reset(reset), .Enable(en_i), .PacketOut(pkt_i), .DnStrFull(full_i),
    .ReqDnStr(req_i), .GntDnStr(gnt_i), .SentCount(cnt_i), .Done(done_i));
  traffic_generator #(.routerID(6'b001_001), .ModuleID(6'd7), .DEST_MODE(1), .INJ_INTERVAL(0), .NUM_PACKETS(0)) u_rnd (
    .clk(clk), .reset(reset), .Enable(en_r), .PacketOut(pkt_r), .DnStrFull(full_r),
    .ReqDnStr(req_r), .GntDnStr(gnt_r), .SentCount(cnt_r), .Done(done_r));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_level(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (cur_req !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (cur_req !== lvl) chk(tag, {63'b0, cur_req}, {63'b0, lvl});
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, prev, highs, bad_self, bad_range, bad_hi;
    logic [15:0] s;
    logic [2:0] x, y;
    logic [31:0] p;
    repeat (3) @(negedge clk);
    chk("rst_pkt", pkt_f, 0);
    chk("rst_req", req_f, 0);
    chk("rst_cnt", cnt_f, 0);
    chk("rst_done", done_f, 0);
    chk("rst_req_rnd", req_r, 0);
    reset = 1;
    @(negedge clk);
    // fixed destination, three packets with a two-cycle gap
    sel = 0;
    exp_q.push_back(32'h000A_0003);
    exp_q.push_back(32'h000A_0043);
    exp_q.push_back(32'h000A_0083);
    en_f = 1;
    auto_f = 1;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_level(1, 20, "req_rise_fix");
      t = cyc;
      if (k > 0) chk("req_period", 64'(t - prev), 5);
      prev = t;
      chk($sformatf("pkt_fix%0d", k), pkt_f, exp_q.pop_front());
      wait_level(0, 20, "req_fall_fix");
    end
    chk("done_with_last_drop", done_f, 1);
    chk("cnt_fix", cnt_f, 3);
    repeat (10) @(negedge clk);
    chk("done_terminal_req", req_f, 0);
    chk("done_sticky", done_f, 1);
    // reset restarts counters, then abandon a request with an async reset
    en_f = 0;
    auto_f = 0;
    reset = 0;
    @(negedge clk);
    reset = 1;
    chk("cnt_after_rst", cnt_f, 0);
    chk("done_after_rst", done_f, 0);
    en_f = 1;
    wait_level(1, 5, "req_rise_pre_rst");
    #2 reset = 0;
    #1 chk("async_rst_req", req_f, 0);
    chk("async_rst_cnt", cnt_f, 0);
    @(negedge clk);
    reset = 1;
    exp_q.push_back(32'h000A_0003);
    wait_level(1, 5, "req_rise_post_rst");
    chk("pkt_post_rst", pkt_f, exp_q.pop_front());
    chk("cnt_post_rst", cnt_f, 0);
    // grant withheld 7 cycles, DnStrFull raised while requesting
    full_f = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("hold_req", req_f, 1);
      chk("hold_pkt", pkt_f, 32'h000A_0003);
    end
    man_f = 1;
    @(negedge clk);
    man_f = 0;
    chk("delayed_gnt_drop", req_f, 0);
    chk("delayed_gnt_cnt", cnt_f, 1);
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req_f) highs++;
    end
    chk("full_blocks_req", 64'(highs), 0);
    chk("full_cnt", cnt_f, 1);
    exp_q.push_back(32'h000A_0043);
    full_f = 0;
    @(negedge clk);
    chk("req_after_full", req_f, 1);
    chk("pkt_after_full", pkt_f, exp_q.pop_front());
    man_f = 1;
    @(negedge clk);
    man_f = 0;
    en_f = 0;
    chk("cnt_after_full", cnt_f, 2);
    // unlimited back-to-back traffic across the PacketID wrap
    sel = 1;
    for (int k = 0; k < 1030; k++) exp_q.push_back({10'b0, 6'b000_001, 10'(k), 6'd5});
    en_i = 1;
    auto_i = 1;
    for (int k = 0; k < 1030; k++) begin
      wait_level(1, 10, "req_rise_inf");
      chk(k == 1024 ? "pid_wrap" : "pkt_inf", pkt_i, exp_q.pop_front());
      wait_level(0, 10, "req_fall_inf");
    end
    en_i = 0;
    repeat (5) @(negedge clk);
    chk("cnt_inf", cnt_i, 1030);
    chk("done_inf", done_i, 0);
    chk("req_inf_idle", req_i, 0);
    // random destinations with self-exclusion
    sel = 2;
    s = 16'hACE1;
    for (int k = 0; k < 1000; k++) begin
      x = 3'(s[2:0] % 4);
      y = 3'(s[5:3] % 4);
      if (x == 3'd1 && y == 3'd1) x = 3'd2;
      exp_q.push_back({10'b0, x, y, 10'(k), 6'd7});
      s = lfsr_next(s);
    end
    bad_self = 0;
    bad_range = 0;
    bad_hi = 0;
    en_r = 1;
    auto_r = 1;
    for (int k = 0; k < 1000; k++) begin
      wait_level(1, 10, "req_rise_rnd");
      p = pkt_r;
      chk("pkt_rnd", p, exp_q.pop_front());
      if (p[21:16] == 6'b001_001) bad_self++;
      if (p[21:19] > 3'd3 || p[18:16] > 3'd3) bad_range++;
      if (p[31:22] != 10'd0) bad_hi++;
      wait_level(0, 10, "req_fall_rnd");
    end
    en_r = 0;
    chk("rnd_self_dest", 64'(bad_self), 0);
    chk("rnd_coord_range", 64'(bad_range), 0);
    chk("rnd_upper_bits", 64'(bad_hi), 0);
    repeat (3) @(negedge clk);
    chk("cnt_rnd", cnt_r, 1000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
